// File: rtl/cmd_arbiter.sv
// Two-source command arbiter for cmd_proc: grants the UART wrapper or TourCmd,
// holds the grant until send_resp or watchdog expiry, routes handshakes to the owner.
module cmd_arbiter #(
  parameter int unsigned TIMEOUT = 5_000_000,
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1)
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [15:0] cmd_UART_i,
  input  logic        cmd_rdy_UART_i,
  output logic        clr_cmd_rdy_UART_o,
  output logic        send_resp_UART_o,
  input  logic [15:0] cmd_tour_i,
  input  logic        cmd_rdy_tour_i,
  output logic        clr_cmd_rdy_tour_o,
  output logic        send_resp_tour_o,
  input  logic        tour_lock_i,
  output logic [15:0] cmd_o,
  output logic        cmd_rdy_o,
  input  logic        clr_cmd_rdy_i,
  input  logic        send_resp_i,
  output logic        owner_o,
  output logic        timeout_o
);

  // state | meaning
  // IDLE  | no grant; winner picked from pending requests
  // ISSUE | command presented (cmd_rdy=1), waiting for clr_cmd_rdy
  // EXEC  | command accepted, waiting for send_resp
  typedef enum logic [1:0] {IDLE, ISSUE, EXEC} state_t;

  state_t            state_q;
  logic [15:0]       cmd_q;
  logic              cmd_rdy_q;
  logic              owner_q;
  logic              timeout_q;
  logic [WD_W-1:0]   wd_q;

  logic busy;
  logic wd_tc;
  logic done;
  logic expire;
  logic clr_fwd;
  logic grant_tour_d;
  logic grant_any_d;

  assign busy   = (state_q != IDLE);
  assign wd_tc  = (wd_q == WD_W'(TIMEOUT - 1));
  assign done   = busy && send_resp_i;
  // Completion beats the watchdog when both land in the same cycle.
  assign expire = busy && wd_tc && !send_resp_i;

  assign clr_fwd = (state_q == ISSUE) && clr_cmd_rdy_i && !expire;

  assign clr_cmd_rdy_UART_o = clr_fwd && !owner_q;
  assign clr_cmd_rdy_tour_o = clr_fwd &&  owner_q;
  assign send_resp_UART_o   = done && !owner_q;
  assign send_resp_tour_o   = done &&  owner_q;

  assign grant_tour_d = tour_lock_i ? cmd_rdy_tour_i : (cmd_rdy_tour_i && !cmd_rdy_UART_i);
  assign grant_any_d  = cmd_rdy_UART_i || cmd_rdy_tour_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cmd_q     <= 16'h0000;
      cmd_rdy_q <= 1'b0;
      owner_q   <= 1'b0;
      timeout_q <= 1'b0;
      wd_q      <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_any_d) begin
            owner_q   <= grant_tour_d;
            cmd_q     <= grant_tour_d ? cmd_tour_i : cmd_UART_i;
            cmd_rdy_q <= 1'b1;
            wd_q      <= '0;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          wd_q <= wd_q + WD_W'(1);
          if (done) begin
            cmd_rdy_q <= 1'b0;
            state_q   <= IDLE;
          end else if (expire) begin
            cmd_rdy_q <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else if (clr_cmd_rdy_i) begin
            cmd_rdy_q <= 1'b0;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          wd_q <= wd_q + WD_W'(1);
          if (done) begin
            state_q <= IDLE;
          end else if (expire) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          cmd_rdy_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign cmd_o     = cmd_q;
  assign cmd_rdy_o = cmd_rdy_q;
  assign owner_o   = owner_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Scoreboard bench for cmd_arbiter: stimulus pushes expected events with their
// cycle stamps, a negedge monitor pops and compares whenever the DUT emits one.
module tb_cmd_arbiter;
  localparam int unsigned TO = 16;
  localparam int EV_GRANT = 0, EV_CLR = 1, EV_RESP = 2, EV_TMO = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd_UART = 16'h0;
  logic        cmd_rdy_UART = 1'b0;
  logic        clr_cmd_rdy_UART, send_resp_UART;
  logic [15:0] cmd_tour = 16'h0;
  logic        cmd_rdy_tour = 1'b0;
  logic        clr_cmd_rdy_tour, send_resp_tour;
  logic        tour_lock = 1'b0;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic        owner, timeout;

  cmd_arbiter #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cmd_UART_i(cmd_UART), .cmd_rdy_UART_i(cmd_rdy_UART),
    .clr_cmd_rdy_UART_o(clr_cmd_rdy_UART), .send_resp_UART_o(send_resp_UART),
    .cmd_tour_i(cmd_tour), .cmd_rdy_tour_i(cmd_rdy_tour),
    .clr_cmd_rdy_tour_o(clr_cmd_rdy_tour), .send_resp_tour_o(send_resp_tour),
    .tour_lock_i(tour_lock), .cmd_o(cmd), .cmd_rdy_o(cmd_rdy),
    .clr_cmd_rdy_i(clr_cmd_rdy), .send_resp_i(send_resp),
    .owner_o(owner), .timeout_o(timeout)
  );

  always #10 clk = ~clk;

  typedef struct {
    int         kind;
    logic [16:0] data;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  logic prev_rdy = 1'b0;
  string kname[4] = '{"grant", "clr", "resp", "timeout"};

  always @(posedge clk) cyc++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int kind, input logic [16:0] data, input int at);
    ev_t e;
    e.kind = kind; e.data = data; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic check_val(input string name, input logic [16:0] act, input logic [16:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h cycle=%0d", name, act, req, cyc);
    end
  endtask

  task automatic got_ev(input int kind, input logic [16:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s: actual data=%h cycle=%0d required no event", kname[kind], data, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.data !== data || e.cyc != cyc) begin
      failures++;
      $display("FAIL %s: actual kind=%s data=%h cycle=%0d required kind=%s data=%h cycle=%0d",
               kname[e.kind], kname[kind], data, cyc, kname[e.kind], e.data, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cmd_rdy && !prev_rdy) got_ev(EV_GRANT, {owner, cmd});
    if (clr_cmd_rdy_UART || clr_cmd_rdy_tour) got_ev(EV_CLR, {15'b0, clr_cmd_rdy_tour, clr_cmd_rdy_UART});
    if (send_resp_UART || send_resp_tour) got_ev(EV_RESP, {15'b0, send_resp_tour, send_resp_UART});
    if (timeout) got_ev(EV_TMO, 17'h0);
    prev_rdy = cmd_rdy;
  end

  // Accept the granted command now (ISSUE), then complete gap cycles later.
  task automatic serve(input bit own, input int gap);
    clr_cmd_rdy = 1'b1;
    expect_ev(EV_CLR, own ? 17'h2 : 17'h1, cyc);
    step(1);
    clr_cmd_rdy = 1'b0;
    if (own) cmd_rdy_tour = 1'b0; else cmd_rdy_UART = 1'b0;
    step(gap);
    send_resp = 1'b1;
    expect_ev(EV_RESP, own ? 17'h2 : 17'h1, cyc);
    step(1);
    send_resp = 1'b0;
  endtask

  int g;

  initial begin
    step(3);
    rst_n = 1'b1;
    check_val("rst_cmd_rdy", {16'b0, cmd_rdy}, 17'h0);
    check_val("rst_cmd", {1'b0, cmd}, 17'h0);
    check_val("rst_owner", {16'b0, owner}, 17'h0);
    check_val("rst_timeout", {16'b0, timeout}, 17'h0);
    check_val("rst_fwd", {13'b0, clr_cmd_rdy_UART, clr_cmd_rdy_tour, send_resp_UART, send_resp_tour}, 17'h0);

    // Single UART command
    cmd_UART = 16'h2345; cmd_rdy_UART = 1'b1;
    expect_ev(EV_GRANT, {1'b0, 16'h2345}, cyc + 1);
    step(1);
    serve(1'b0, 4);

    // Both request, no lock: UART first, tour two cycles after completion
    cmd_UART = 16'h1111; cmd_tour = 16'hA0A0;
    cmd_rdy_UART = 1'b1; cmd_rdy_tour = 1'b1;
    expect_ev(EV_GRANT, {1'b0, 16'h1111}, cyc + 1);
    step(1);
    serve(1'b0, 3);
    expect_ev(EV_GRANT, {1'b1, 16'hA0A0}, cyc + 1);
    step(1);
    serve(1'b1, 2);

    // Both request with tour_lock: tour first
    tour_lock = 1'b1;
    cmd_UART = 16'h2222; cmd_tour = 16'hB0B0;
    cmd_rdy_UART = 1'b1; cmd_rdy_tour = 1'b1;
    expect_ev(EV_GRANT, {1'b1, 16'hB0B0}, cyc + 1);
    step(1);
    tour_lock = 1'b0;
    serve(1'b1, 2);
    expect_ev(EV_GRANT, {1'b0, 16'h2222}, cyc + 1);
    step(1);
    serve(1'b0, 2);

    // Watchdog expiry, then a late send_resp that must be ignored
    cmd_UART = 16'h3333; cmd_rdy_UART = 1'b1;
    g = cyc + 1;
    expect_ev(EV_GRANT, {1'b0, 16'h3333}, g);
    step(1);
    clr_cmd_rdy = 1'b1;
    expect_ev(EV_CLR, 17'h1, g);
    expect_ev(EV_TMO, 17'h0, g + TO);
    step(1);
    clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
    step(g + TO + 1 - cyc);
    send_resp = 1'b1;
    step(1);
    send_resp = 1'b0;
    step(1);

    // clr and send_resp in the same ISSUE cycle
    cmd_tour = 16'hC0C0; cmd_rdy_tour = 1'b1;
    g = cyc + 1;
    expect_ev(EV_GRANT, {1'b1, 16'hC0C0}, g);
    step(1);
    clr_cmd_rdy = 1'b1; send_resp = 1'b1;
    expect_ev(EV_CLR, 17'h2, g);
    expect_ev(EV_RESP, 17'h2, g);
    step(1);
    clr_cmd_rdy = 1'b0; send_resp = 1'b0; cmd_rdy_tour = 1'b0;

    // Completion exactly at terminal count; stray clr in EXEC ignored
    cmd_UART = 16'h4444; cmd_rdy_UART = 1'b1;
    g = cyc + 1;
    expect_ev(EV_GRANT, {1'b0, 16'h4444}, g);
    step(1);
    clr_cmd_rdy = 1'b1;
    expect_ev(EV_CLR, 17'h1, g);
    step(1);
    clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;
    step(3);
    clr_cmd_rdy = 1'b1;
    step(1);
    clr_cmd_rdy = 1'b0;
    step(g + TO - 1 - cyc);
    send_resp = 1'b1;
    expect_ev(EV_RESP, 17'h1, g + TO - 1);
    step(1);
    send_resp = 1'b0;
    step(2);

    // Async reset during EXEC, request kept pending across it
    cmd_tour = 16'hD0D0; cmd_rdy_tour = 1'b1;
    g = cyc + 1;
    expect_ev(EV_GRANT, {1'b1, 16'hD0D0}, g);
    step(1);
    clr_cmd_rdy = 1'b1;
    expect_ev(EV_CLR, 17'h2, g);
    step(1);
    clr_cmd_rdy = 1'b0;
    step(2);
    rst_n = 1'b0; send_resp = 1'b1;
    #1;
    check_val("mid_rst_cmd_rdy", {16'b0, cmd_rdy}, 17'h0);
    check_val("mid_rst_cmd", {1'b0, cmd}, 17'h0);
    check_val("mid_rst_owner", {16'b0, owner}, 17'h0);
    check_val("mid_rst_fwd", {15'b0, send_resp_tour, send_resp_UART}, 17'h0);
    step(2);
    send_resp = 1'b0;
    rst_n = 1'b1;
    expect_ev(EV_GRANT, {1'b1, 16'hD0D0}, cyc + 1);
    step(1);
    serve(1'b1, 1);

    step(4);
    check_val("pending_events", 17'(exp_q.size()), 17'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL time_limit: actual=expired required=finish");
    $fatal(1, "time limit");
  end

endmodule
